write_pulse_seq: RTL and testbench
==================================

Name: write_pulse_seq

Overview:
- Sequences a single RRAM write operation on the analog block: a SET or RESET pulse, or an OP_TEST_CPULSE charge-test pulse.
- The programming FSM hands over one fully-resolved pulse (address, data mask, DAC levels, pulse width, setup cycles). This block drives the analog control pins with correct enable ordering, pulse width and signal stability, then reports done.
- It sits between the programming FSM and the analog macro pins.

Parameters:
- WORD_SIZE, 48, data word width (di).
- ADDR_BITS_N, 16, RRAM address width.
- BSL_DAC_BITS_N, 5, BL/SL DAC code width.
- WL_DAC_BITS_N, 8, WL DAC code width.
- PW_BITS_N, 8, pulse-width counter width.
- SETUP_CYC_BITS_N, 6, setup counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- start  in  1  one-cycle request; accepted only in IDLE.
- test_cpulse  in  1  1 = charge-test pulse; 0 = normal write.
- set_rst_in  in  1  1 = SET, 0 = RESET.
- addr_in  in  ADDR_BITS_N  target address.
- di_mask_in  in  WORD_SIZE  bit mask of columns to program.
- bsl_lvl_in  in  BSL_DAC_BITS_N  BL (SET) or SL (RESET) DAC code.
- wl_lvl_in  in  WL_DAC_BITS_N  WL DAC code.
- pw_in  in  PW_BITS_N  pulse width in cycles.
- setup_in  in  SETUP_CYC_BITS_N  pre-pulse setup cycles.
- all_dacs_on  in  1  global: keep all DAC enables high.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- aclk, we, bl_en, sl_en, wl_en, bsl_dac_en, wl_dac_en, bleed_en, read_dac_en, set_rst  out  1 each  analog controls.
- bsl_dac_config  out  BSL_DAC_BITS_N  BL/SL DAC code.
- wl_dac_config  out  WL_DAC_BITS_N  WL DAC code.
- di  out  WORD_SIZE  column data.
- rram_addr  out  ADDR_BITS_N  row/word address.

Behaviour:
- All outputs are registered.
- Reset (rst = 1 at posedge): state = IDLE. Every output is 0, except bsl_dac_en, wl_dac_en, bleed_en and read_dac_en, which equal all_dacs_on. Reset mid-operation aborts the operation with no done pulse.
- Accept: at posedge with state = IDLE and start = 1, capture all *_in inputs. start in any other state is ignored.
- Derived values from captured inputs:
  - set_rst = set_rst_in.
  - di = di_mask_in XNOR {WORD_SIZE{set_rst_in}}.
  - rram_addr = addr_in.
  - bsl_dac_config = bsl_lvl_in; wl_dac_config = wl_lvl_in.
  - These outputs are held constant from the first non-IDLE cycle through DONE.
- Widths and clamps:
  - PWN = max(pw_in, 1).
  - SUN = max(setup_in, 1). The minimum of 1 guarantees all enables are high the cycle before we rises.
  - PWC = min(max(pw_in, 1), 3).
  - Counters load N-1 and decrement to 0; no wrap-around.
- Normal write (test_cpulse = 0):
  - SETUP, SUN cycles: bl_en = sl_en = wl_en = bsl_dac_en = wl_dac_en = 1; we = aclk = 0.
  - PULSE, PWN cycles: as SETUP, plus we = aclk = 1.
  - DONE, 1 cycle: all enables and we/aclk = 0; done = 1.
  - Back to IDLE.
- Charge-test pulse (test_cpulse = 1); aclk stays 0 throughout:
  - CP_BL, PWC cycles: bl_en = sl_en = we = 1, wl_en = 0.
  - CP_GAP, 1 cycle: bl_en = 0, sl_en = we = 1, wl_en = 0.
  - CP_WL, PWC cycles: wl_en = sl_en = we = 1, bl_en = 0.
  - DONE, 1 cycle: all 0; done = 1.
  - bsl_dac_en and wl_dac_en are 1 from CP_BL through CP_WL.
- In every state: bleed_en = read_dac_en = all_dacs_on; bsl_dac_en = wl_dac_en = 1 whenever all_dacs_on = 1.
- In normal mode, aclk == we on every cycle.
- busy = 1 in every state except IDLE.
- done and start in the same cycle: start is ignored; a new start is accepted at the earliest in the cycle after returning to IDLE.
- Latency from start posedge to done: normal = SUN + PWN + 1 cycles; charge pulse = 2*PWC + 2 cycles.

Test Plan:
- SET, setup_in = 2, pw_in = 4, di_mask = 0x00000000000F, all_dacs_on = 0 -> enables high at cycle 1; we/aclk high at cycles 3–6; done at cycle 7; di = 0x00000000000F throughout; bleed_en = 0.
- RESET, setup_in = 0, pw_in = 0, mask = 0x1 -> SUN = PWN = 1; we high at cycle 2 only; di = 0xFFFFFFFFFFFE; done at cycle 3.
- Charge pulse, pw_in = 10 -> bl_en high at cycles 1–3; gap at cycle 4; wl_en high at cycles 5–7; sl_en/we fall at cycle 8 with done; aclk = 0 throughout.
- all_dacs_on = 1 while idle and during a write -> all four DAC enables = 1 on every cycle, including IDLE.
- rst asserted during PULSE -> next cycle all outputs at reset values; no done; busy = 0.
- start re-pulsed during SETUP and on the done cycle -> both ignored; registered outputs unchanged; a start one cycle after IDLE is re-entered is accepted.

Source files
------------

// File: rtl/write_pulse_seq.sv
// rtl/write_pulse_seq.sv - RRAM write/charge-test pulse sequencer driving the analog control pins
module write_pulse_seq #(
    parameter int WORD_SIZE        = 48,
    parameter int ADDR_BITS_N      = 16,
    parameter int BSL_DAC_BITS_N   = 5,
    parameter int WL_DAC_BITS_N    = 8,
    parameter int PW_BITS_N        = 8,
    parameter int SETUP_CYC_BITS_N = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        test_cpulse,
    input  logic                        set_rst_in,
    input  logic [ADDR_BITS_N-1:0]      addr_in,
    input  logic [WORD_SIZE-1:0]        di_mask_in,
    input  logic [BSL_DAC_BITS_N-1:0]   bsl_lvl_in,
    input  logic [WL_DAC_BITS_N-1:0]    wl_lvl_in,
    input  logic [PW_BITS_N-1:0]        pw_in,
    input  logic [SETUP_CYC_BITS_N-1:0] setup_in,
    input  logic                        all_dacs_on,
    output logic                        busy,
    output logic                        done,
    output logic                        aclk,
    output logic                        we,
    output logic                        bl_en,
    output logic                        sl_en,
    output logic                        wl_en,
    output logic                        bsl_dac_en,
    output logic                        wl_dac_en,
    output logic                        bleed_en,
    output logic                        read_dac_en,
    output logic                        set_rst,
    output logic [BSL_DAC_BITS_N-1:0]   bsl_dac_config,
    output logic [WL_DAC_BITS_N-1:0]    wl_dac_config,
    output logic [WORD_SIZE-1:0]        di,
    output logic [ADDR_BITS_N-1:0]      rram_addr
);

    localparam int CNT_W = (PW_BITS_N > SETUP_CYC_BITS_N) ? PW_BITS_N : SETUP_CYC_BITS_N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_CP_BL,
        S_CP_GAP,
        S_CP_WL,
        S_DONE
    } state_t;

    state_t             state, state_d, state_n;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   pwn_m1_q;
    logic [1:0]         pwc_m1_q;

    logic [CNT_W-1:0]   pw_ext, su_ext;
    logic [CNT_W-1:0]   pwn_m1_in, sun_m1_in;
    logic [1:0]         pwc_m1_in;
    logic               accept;

    logic busy_d, done_d, aclk_d, we_d, bl_d, sl_d, wl_d, bdac_d, wdac_d;

    assign accept = (state == S_IDLE) && start;

    // Clamped counter reload values: widths of 0 behave as 1, charge pulse capped at 3
    always_comb begin
        pw_ext    = CNT_W'(pw_in);
        su_ext    = CNT_W'(setup_in);
        pwn_m1_in = (pw_ext == '0) ? '0 : pw_ext - CNT_W'(1);
        sun_m1_in = (su_ext == '0) ? '0 : su_ext - CNT_W'(1);
        if (pw_ext >= CNT_W'(3))
            pwc_m1_in = 2'd2;
        else if (pw_ext == '0)
            pwc_m1_in = 2'd0;
        else
            pwc_m1_in = pw_ext[1:0] - 2'd1;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (test_cpulse) begin
                        state_d = S_CP_BL;
                        cnt_d   = CNT_W'(pwc_m1_in);
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = sun_m1_in;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = pwn_m1_q;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt == '0) state_d = S_DONE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_CP_BL: begin
                if (cnt == '0) state_d = S_CP_GAP;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_CP_GAP: begin
                state_d = S_CP_WL;
                cnt_d   = CNT_W'(pwc_m1_q);
            end
            S_CP_WL: begin
                if (cnt == '0) state_d = S_DONE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values are decoded from the upcoming state so the output flops line up with it
    always_comb begin
        state_n = rst ? S_IDLE : state_d;
        busy_d  = (state_n != S_IDLE);
        done_d  = 1'b0;
        aclk_d  = 1'b0;
        we_d    = 1'b0;
        bl_d    = 1'b0;
        sl_d    = 1'b0;
        wl_d    = 1'b0;
        bdac_d  = all_dacs_on;
        wdac_d  = all_dacs_on;
        case (state_n)
            S_SETUP: begin
                bl_d = 1'b1; sl_d = 1'b1; wl_d = 1'b1; bdac_d = 1'b1; wdac_d = 1'b1;
            end
            S_PULSE: begin
                bl_d = 1'b1; sl_d = 1'b1; wl_d = 1'b1; bdac_d = 1'b1; wdac_d = 1'b1;
                we_d = 1'b1; aclk_d = 1'b1;
            end
            S_CP_BL: begin
                bl_d = 1'b1; sl_d = 1'b1; we_d = 1'b1; bdac_d = 1'b1; wdac_d = 1'b1;
            end
            S_CP_GAP: begin
                sl_d = 1'b1; we_d = 1'b1; bdac_d = 1'b1; wdac_d = 1'b1;
            end
            S_CP_WL: begin
                wl_d = 1'b1; sl_d = 1'b1; we_d = 1'b1; bdac_d = 1'b1; wdac_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        state       <= state_n;
        busy        <= busy_d;
        done        <= done_d;
        aclk        <= aclk_d;
        we          <= we_d;
        bl_en       <= bl_d;
        sl_en       <= sl_d;
        wl_en       <= wl_d;
        bsl_dac_en  <= bdac_d;
        wl_dac_en   <= wdac_d;
        bleed_en    <= all_dacs_on;
        read_dac_en <= all_dacs_on;
        if (rst) begin
            cnt            <= '0;
            pwn_m1_q       <= '0;
            pwc_m1_q       <= '0;
            set_rst        <= 1'b0;
            di             <= '0;
            rram_addr      <= '0;
            bsl_dac_config <= '0;
            wl_dac_config  <= '0;
        end else begin
            cnt <= cnt_d;
            if (accept) begin
                pwn_m1_q       <= pwn_m1_in;
                pwc_m1_q       <= pwc_m1_in;
                set_rst        <= set_rst_in;
                di             <= di_mask_in ~^ {WORD_SIZE{set_rst_in}};
                rram_addr      <= addr_in;
                bsl_dac_config <= bsl_lvl_in;
                wl_dac_config  <= wl_lvl_in;
            end
        end
    end

endmodule

// File: tb/tb_write_pulse_seq.sv
// tb/tb_write_pulse_seq.sv - self-checking bench for write_pulse_seq
module tb_write_pulse_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        test_cpulse;
    logic        set_rst_in;
    logic [15:0] addr_in;
    logic [47:0] di_mask_in;
    logic [4:0]  bsl_lvl_in;
    logic [7:0]  wl_lvl_in;
    logic [7:0]  pw_in;
    logic [5:0]  setup_in;
    logic        all_dacs_on;
    logic        busy, done, aclk, we, bl_en, sl_en, wl_en;
    logic        bsl_dac_en, wl_dac_en, bleed_en, read_dac_en, set_rst;
    logic [4:0]  bsl_dac_config;
    logic [7:0]  wl_dac_config;
    logic [47:0] di;
    logic [15:0] rram_addr;

    int n_cmp = 0;
    int n_bad = 0;

    write_pulse_seq dut (
        .clk(clk), .rst(rst), .start(start), .test_cpulse(test_cpulse),
        .set_rst_in(set_rst_in), .addr_in(addr_in), .di_mask_in(di_mask_in),
        .bsl_lvl_in(bsl_lvl_in), .wl_lvl_in(wl_lvl_in), .pw_in(pw_in),
        .setup_in(setup_in), .all_dacs_on(all_dacs_on), .busy(busy), .done(done),
        .aclk(aclk), .we(we), .bl_en(bl_en), .sl_en(sl_en), .wl_en(wl_en),
        .bsl_dac_en(bsl_dac_en), .wl_dac_en(wl_dac_en), .bleed_en(bleed_en),
        .read_dac_en(read_dac_en), .set_rst(set_rst), .bsl_dac_config(bsl_dac_config),
        .wl_dac_config(wl_dac_config), .di(di), .rram_addr(rram_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tc;
        bit          sr;
        logic [15:0] addr;
        logic [47:0] mask;
        logic [4:0]  bsl;
        logic [7:0]  wl;
        logic [7:0]  pw;
        logic [5:0]  su;
        bit          adon;
        logic [31:0] pokes;
        int          exp_lat;
        logic [47:0] exp_di;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] ctrl_now();
        return {busy, done, aclk, we, bl_en, sl_en, wl_en,
                bsl_dac_en, wl_dac_en, bleed_en, read_dac_en};
    endfunction

    // Expected pins at cycle k after the accepting edge (k = 0 or k > len means idle)
    function automatic logic [10:0] model_ctrl(input bit tc, input int k, input int len,
                                               input int sun, input int pwc, input bit adon);
        bit b = 0, d = 0, ac = 0, w = 0, bl = 0, sl = 0, wl = 0, bd = 0, wd = 0;
        if (k >= 1 && k < len) begin
            b = 1;
            if (!tc) begin
                bl = 1; sl = 1; wl = 1; bd = 1; wd = 1;
                if (k > sun) begin w = 1; ac = 1; end
            end else begin
                sl = 1; w = 1; bd = 1; wd = 1;
                if (k <= pwc) bl = 1;
                else if (k > pwc + 1) wl = 1;
            end
        end else if (k >= 1 && k == len) begin
            b = 1; d = 1;
        end
        bd = bd | adon;
        wd = wd | adon;
        return {b, d, ac, w, bl, sl, wl, bd, wd, adon, adon};
    endfunction

    task automatic scramble_inputs();
        test_cpulse = 1'($urandom());
        set_rst_in  = 1'($urandom());
        addr_in     = 16'($urandom());
        di_mask_in  = {16'($urandom()), $urandom()};
        bsl_lvl_in  = 5'($urandom());
        wl_lvl_in   = 8'($urandom());
        pw_in       = 8'($urandom());
        setup_in    = 6'($urandom());
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after done
    task automatic run_op(input vec_t v, input string tag);
        int sun, pwn, pwc, len, done_at;
        logic [81:0] exp_der;
        sun = (v.su == 0) ? 1 : int'(v.su);
        pwn = (v.pw == 0) ? 1 : int'(v.pw);
        pwc = (pwn > 3) ? 3 : pwn;
        len = v.tc ? 2 * pwc + 2 : sun + pwn + 1;
        exp_der = {4'b0, v.sr, v.exp_di, v.addr, v.bsl, v.wl};
        test_cpulse = v.tc;  set_rst_in = v.sr;  addr_in = v.addr;
        di_mask_in  = v.mask; bsl_lvl_in = v.bsl; wl_lvl_in = v.wl;
        pw_in = v.pw; setup_in = v.su; all_dacs_on = v.adon;
        start = 1'b1;
        done_at = -1;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            check({tag, "_ctrl"}, ctrl_now(), model_ctrl(v.tc, k, len, sun, pwc, v.adon));
            if (k <= len)
                check({tag, "_data"}, {4'b0, set_rst, di, rram_addr, bsl_dac_config, wl_dac_config},
                      exp_der);
            if (done && done_at < 0) done_at = k;
            start = 1'b0;
            if (k <= len && k < 32 && v.pokes[k]) begin
                start = 1'b1;
                scramble_inputs();
            end
        end
        check({tag, "_latency"}, done_at, v.exp_lat);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{0, 1, 16'h1234, 48'h00000000000F, 5'd7,  8'h40, 8'd4,  6'd2, 0, 32'h0,  7, 48'h00000000000F};
        tbl[1] = '{0, 0, 16'h0001, 48'h000000000001, 5'd3,  8'h11, 8'd0,  6'd0, 0, 32'h0,  3, 48'hFFFFFFFFFFFE};
        tbl[2] = '{1, 1, 16'hBEEF, 48'h000000000ABC, 5'd31, 8'hFF, 8'd10, 6'd4, 0, 32'h0,  8, 48'h000000000ABC};
        tbl[3] = '{0, 1, 16'h8000, 48'h123456789ABC, 5'd1,  8'h01, 8'd1,  6'd1, 1, 32'h0,  3, 48'h123456789ABC};
        tbl[4] = '{0, 0, 16'hFFFF, 48'h000000000000, 5'd16, 8'h80, 8'd3,  6'd5, 1, 32'h0,  9, 48'hFFFFFFFFFFFF};
        tbl[5] = '{1, 0, 16'h00AA, 48'h0000000000FF, 5'd9,  8'h5A, 8'd1,  6'd9, 1, 32'h0,  4, 48'hFFFFFFFFFF00};
        tbl[6] = '{1, 1, 16'h0F0F, 48'h800000000001, 5'd2,  8'hA5, 8'd2,  6'd0, 0, 32'h0,  6, 48'h800000000001};
        tbl[7] = '{1, 0, 16'h7777, 48'hFFFFFFFFFFFF, 5'd5,  8'h33, 8'd0,  6'd0, 0, 32'h0,  4, 48'h000000000000};
        tbl[8] = '{0, 1, 16'h4242, 48'h000000005555, 5'd12, 8'h66, 8'd2,  6'd3, 0, 32'h42, 6, 48'h000000005555};

        rst = 1'b1; start = 1'b0; all_dacs_on = 1'b1;
        test_cpulse = 0; set_rst_in = 0; addr_in = '0; di_mask_in = '0;
        bsl_lvl_in = '0; wl_lvl_in = '0; pw_in = '0; setup_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", ctrl_now(), model_ctrl(0, 0, 1, 1, 1, 1'b1));
        check("reset_data", {set_rst, di, rram_addr, bsl_dac_config, wl_dac_config}, '0);
        rst = 1'b0;
        all_dacs_on = 1'b0;
        @(negedge clk);
        check("idle_ctrl", ctrl_now(), model_ctrl(0, 0, 1, 1, 1, 1'b0));

        for (int i = 0; i < 9; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset during the PULSE phase: no done, outputs back to reset values
        test_cpulse = 0; set_rst_in = 1; addr_in = 16'h2222; di_mask_in = 48'h3;
        bsl_lvl_in = 5'd4; wl_lvl_in = 8'd9; pw_in = 8'd5; setup_in = 6'd2; all_dacs_on = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_pulse", ctrl_now(), model_ctrl(0, 4, 8, 2, 3, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_ctrl", ctrl_now(), model_ctrl(0, 0, 1, 1, 1, 1'b0));
        check("midop_rst_data", {set_rst, di, rram_addr, bsl_dac_config, wl_dac_config}, '0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_idle", ctrl_now(), model_ctrl(0, 0, 1, 1, 1, 1'b0));
        end

        for (int i = 0; i < 40; i++) begin
            int sun, pwn, pwc;
            rv.tc   = 1'($urandom());
            rv.sr   = 1'($urandom());
            rv.addr = 16'($urandom());
            rv.mask = {16'($urandom()), $urandom()};
            rv.bsl  = 5'($urandom());
            rv.wl   = 8'($urandom());
            rv.pw   = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 12));
            rv.su   = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : 6'($urandom_range(0, 8));
            rv.adon = 1'($urandom());
            rv.pokes = $urandom() & 32'hFFFF_FFFE;
            sun = (rv.su == 0) ? 1 : int'(rv.su);
            pwn = (rv.pw == 0) ? 1 : int'(rv.pw);
            pwc = (pwn > 3) ? 3 : pwn;
            rv.exp_lat = rv.tc ? 2 * pwc + 2 : sun + pwn + 1;
            rv.exp_di  = rv.sr ? rv.mask : ~rv.mask;
            run_op(rv, $sformatf("rnd%0d", i));
        end

        start = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
